// File: rtl/clarke_sampler.sv
`default_nettype none
// ============================================================================
// Module   : clarke_sampler
// Brief    : Collects round-robin ADC frames, averages a block, scales to Q
//            amps/volts and applies the Clarke transform for the kalman stage.
// Revision : 1.0 - initial release
// ============================================================================
module clarke_sampler #(
    parameter int N         = 32,
    parameter int Q         = 18,
    parameter int ADC_W     = 12,
    parameter int AVG_LOG2  = 2,
    parameter int I_GAIN    = 2560,
    parameter int V_GAIN    = 51200,
    parameter int INV_SQRT3 = 151349
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adc_valid,
    input  logic [1:0]          adc_chan,
    input  logic [ADC_W-1:0]    adc_data,
    output logic signed [N-1:0] ialpham,
    output logic signed [N-1:0] ibetam,
    output logic signed [N-1:0] valpha,
    output logic signed [N-1:0] vbeta,
    output logic                out_valid,
    output logic                overrun,
    output logic                sat_flag,
    output logic [7:0]          err_count
);
    localparam int c_CODE_W = ADC_W + 1;
    localparam int c_ACC_W  = ADC_W + 1 + AVG_LOG2;
    localparam int c_FCNT_W = AVG_LOG2 + 1;
    localparam int c_FRAMES = 1 << AVG_LOG2;
    localparam int c_MA_W   = N + 2;
    localparam int c_P_W    = 2 * N + 2;

    localparam logic signed [N-1:0] c_I_GAIN  = N'(I_GAIN);
    localparam logic signed [N-1:0] c_V_GAIN  = N'(V_GAIN);
    localparam logic signed [N-1:0] c_INV     = N'(INV_SQRT3);
    localparam logic signed [N-1:0] c_SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] c_SAT_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [c_CODE_W-1:0] c_MID = {2'b01, {(ADC_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_PUB  = 2'd2;

    logic signed [c_CODE_W-1:0] w_code;
    logic                       w_match;
    logic                       w_frame_done;
    logic                       w_block_done;
    logic                       w_accept;
    logic signed [c_ACC_W-1:0]  w_sum   [4];

    logic [1:0]                 r_exp;
    logic [c_FCNT_W-1:0]        r_fcnt;
    logic [7:0]                 r_err;
    logic signed [c_CODE_W-1:0] r_frame [3];
    logic signed [c_ACC_W-1:0]  r_acc   [4];
    logic signed [c_ACC_W-1:0]  r_hold  [4];

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [2:0]                 r_k;
    logic [2:0]                 w_k_nxt;

    logic signed [c_ACC_W-1:0]  w_avg;
    logic signed [c_MA_W-1:0]   w_ma;
    logic signed [N-1:0]        w_mb;
    logic signed [c_P_W-1:0]    w_prod;
    logic signed [c_P_W-1:0]    w_shifted;
    logic [N+2:0]               w_hi;
    logic                       w_ovf;
    logic signed [N-1:0]        w_res;

    logic signed [N-1:0]        r_x [4];
    logic signed [N-1:0]        r_ibeta;
    logic signed [N-1:0]        r_vbeta;
    logic signed [N-1:0]        r_ialpham;
    logic signed [N-1:0]        r_ibetam;
    logic signed [N-1:0]        r_valpha;
    logic signed [N-1:0]        r_vbeta_o;
    logic                       r_valid;
    logic                       r_overrun;
    logic                       r_sat;

    assign w_code       = $signed({1'b0, adc_data}) - c_MID;
    assign w_match      = adc_valid && (adc_chan == r_exp);
    assign w_frame_done = w_match && (r_exp == 2'd3);
    assign w_block_done = w_frame_done && (r_fcnt == c_FCNT_W'(c_FRAMES - 1));
    assign w_accept     = w_block_done && (r_state != S_MUL);

    // Block sums include the word being accepted so completion needs no extra cycle
    for (genvar g = 0; g < 4; g++) begin : g_sum
        if (g == 3) begin : g_last
            assign w_sum[g] = r_acc[g] + c_ACC_W'(w_code);
        end else begin : g_part
            assign w_sum[g] = r_acc[g] + c_ACC_W'(r_frame[g]);
        end
    end

    // Partial-frame words live in r_frame so a framing error never touches r_acc
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp  <= 2'd0;
            r_fcnt <= '0;
            r_err  <= 8'd0;
            for (int k = 0; k < 3; k++) r_frame[k] <= '0;
            for (int k = 0; k < 4; k++) begin
                r_acc[k]  <= '0;
                r_hold[k] <= '0;
            end
        end else if (adc_valid) begin
            if (w_match) begin
                case (r_exp)
                    2'd0:    r_frame[0] <= w_code;
                    2'd1:    r_frame[1] <= w_code;
                    2'd2:    r_frame[2] <= w_code;
                    default: ;
                endcase
                if (w_frame_done) begin
                    r_exp <= 2'd0;
                    if (w_block_done) begin
                        r_fcnt <= '0;
                        for (int k = 0; k < 4; k++) r_acc[k] <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + c_FCNT_W'(1);
                        for (int k = 0; k < 4; k++) r_acc[k] <= w_sum[k];
                    end
                end else begin
                    r_exp <= r_exp + 2'd1;
                end
            end else begin
                if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                if (adc_chan == 2'd0) begin
                    r_frame[0] <= w_code;
                    r_exp      <= 2'd1;
                end else begin
                    r_exp <= 2'd0;
                end
            end
            if (w_accept) begin
                for (int k = 0; k < 4; k++) r_hold[k] <= w_sum[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_MUL;
                    w_k_nxt     = 3'd0;
                end
            end
            S_MUL: begin
                if (r_k == 3'd5) w_state_nxt = S_PUB;
                else             w_k_nxt     = r_k + 3'd1;
            end
            S_PUB: begin
                if (w_accept) begin
                    w_state_nxt = S_MUL;
                    w_k_nxt     = 3'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shared multiplier: steps 0..3 scale the averages, 4..5 form the beta terms
    always_comb begin
        w_avg = r_hold[r_k[1:0]] >>> AVG_LOG2;
        w_ma  = c_MA_W'(w_avg);
        w_mb  = c_I_GAIN;
        case (r_k)
            3'd0, 3'd1: w_mb = c_I_GAIN;
            3'd2, 3'd3: w_mb = c_V_GAIN;
            3'd4: begin
                w_ma = c_MA_W'(r_x[0]) + (c_MA_W'(r_x[1]) <<< 1);
                w_mb = c_INV;
            end
            3'd5: begin
                w_ma = c_MA_W'(r_x[2]) + (c_MA_W'(r_x[3]) <<< 1);
                w_mb = c_INV;
            end
            default: ;
        endcase
        w_prod    = c_P_W'(w_ma) * c_P_W'(w_mb);
        w_shifted = (r_k >= 3'd4) ? (w_prod >>> Q) : w_prod;
        w_hi      = w_shifted[c_P_W-1:N-1];
        w_ovf     = !((&w_hi) || !(|w_hi));
        w_res     = w_ovf ? (w_hi[N+2] ? c_SAT_MIN : c_SAT_MAX) : w_shifted[N-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) r_x[k] <= '0;
            r_ibeta   <= '0;
            r_vbeta   <= '0;
            r_ialpham <= '0;
            r_ibetam  <= '0;
            r_valpha  <= '0;
            r_vbeta_o <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= w_block_done && (r_state == S_MUL);
            if (r_state == S_MUL) begin
                case (r_k)
                    3'd0, 3'd1, 3'd2, 3'd3: r_x[r_k[1:0]] <= w_res;
                    3'd4:                   r_ibeta       <= w_res;
                    3'd5:                   r_vbeta       <= w_res;
                    default: ;
                endcase
                if (w_ovf) r_sat <= 1'b1;
            end
            if (r_state == S_PUB) begin
                r_ialpham <= r_x[0];
                r_ibetam  <= r_ibeta;
                r_valpha  <= r_x[2];
                r_vbeta_o <= r_vbeta;
                r_valid   <= 1'b1;
            end
        end
    end

    assign ialpham   = r_ialpham;
    assign ibetam    = r_ibetam;
    assign valpha    = r_valpha;
    assign vbeta     = r_vbeta_o;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
    assign sat_flag  = r_sat;
    assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clarke_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_clarke_sampler
// Brief    : Directed and random blocks checked against a frame-level
//            arithmetic model of averaging, gain scaling and Clarke transform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clarke_sampler;
    localparam longint c_G18 = 262144;
    localparam longint c_G22 = 4194304;
    localparam longint c_IG1 = 2560;
    localparam longint c_INV = 151349;
    localparam longint c_MAX = 2147483647;
    localparam longint c_MIN = -64'sd2147483648;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        r_v0 = 1'b0, r_v1 = 1'b0;
    logic [1:0]  r_c0 = 2'd0, r_c1 = 2'd0;
    logic [11:0] r_d0 = 12'd0, r_d1 = 12'd0;
    logic signed [31:0] w_ia0, w_ib0, w_va0, w_vb0;
    logic signed [31:0] w_ia1, w_ib1, w_va1, w_vb1;
    logic w_ov0, w_or0, w_sat0, w_ov1, w_or1, w_sat1;
    logic [7:0] w_err0, w_err1;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint r_sum [2][4];
    longint m_out [4];
    bit     m_sat;
    bit     esat [2];

    always #5 clk = ~clk;

    clarke_sampler #(.AVG_LOG2(2), .I_GAIN(262144), .V_GAIN(262144)) u_dut0 (
        .clk(clk), .reset(reset), .adc_valid(r_v0), .adc_chan(r_c0), .adc_data(r_d0),
        .ialpham(w_ia0), .ibetam(w_ib0), .valpha(w_va0), .vbeta(w_vb0),
        .out_valid(w_ov0), .overrun(w_or0), .sat_flag(w_sat0), .err_count(w_err0));

    clarke_sampler #(.AVG_LOG2(0), .I_GAIN(2560), .V_GAIN(4194304)) u_dut1 (
        .clk(clk), .reset(reset), .adc_valid(r_v1), .adc_chan(r_c1), .adc_data(r_d1),
        .ialpham(w_ia1), .ibetam(w_ib1), .valpha(w_va1), .vbeta(w_vb1),
        .out_valid(w_ov1), .overrun(w_or1), .sat_flag(w_sat1), .err_count(w_err1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((q * d) != a && ((a < 0) != (d < 0))) q = q - 1;
        return q;
    endfunction

    function automatic bit ovr(input longint x);
        return (x > c_MAX) || (x < c_MIN);
    endfunction

    function automatic longint clip(input longint x);
        if (x > c_MAX) return c_MAX;
        if (x < c_MIN) return c_MIN;
        return x;
    endfunction

    // Average, scale, then Clarke on the bench's own per-channel block sums
    function automatic void model(input int which);
        longint x [4];
        longint d, ig, vg, t;
        d  = (which == 0) ? 64'sd4 : 64'sd1;
        ig = (which == 0) ? c_G18 : c_IG1;
        vg = (which == 0) ? c_G18 : c_G22;
        m_sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            x[k] = fdiv(r_sum[which][k], d) * ((k < 2) ? ig : vg);
            if (ovr(x[k])) m_sat = 1'b1;
            x[k] = clip(x[k]);
        end
        m_out[0] = x[0];
        m_out[2] = x[2];
        t = fdiv((x[0] + 2 * x[1]) * c_INV, c_G18);
        if (ovr(t)) m_sat = 1'b1;
        m_out[1] = clip(t);
        t = fdiv((x[2] + 2 * x[3]) * c_INV, c_G18);
        if (ovr(t)) m_sat = 1'b1;
        m_out[3] = clip(t);
    endfunction

    function automatic longint dout(input int which, input int idx);
        logic signed [31:0] v;
        case (idx)
            0:       v = (which == 0) ? w_ia0 : w_ia1;
            1:       v = (which == 0) ? w_ib0 : w_ib1;
            2:       v = (which == 0) ? w_va0 : w_va1;
            default: v = (which == 0) ? w_vb0 : w_vb1;
        endcase
        return longint'(v);
    endfunction

    task automatic put(input int which, input int ch, input int data);
        logic [1:0]  c;
        logic [11:0] d;
        c = ch[1:0];
        d = data[11:0];
        if (which == 0) begin r_v0 = 1'b1; r_c0 = c; r_d0 = d; end
        else            begin r_v1 = 1'b1; r_c1 = c; r_d1 = d; end
        tick;
        r_v0 = 1'b0;
        r_v1 = 1'b0;
    endtask

    task automatic frame(input int which, input int a, input int b, input int c, input int d);
        put(which, 0, a); put(which, 1, b); put(which, 2, c); put(which, 3, d);
        r_sum[which][0] += longint'(a) - 2048;
        r_sum[which][1] += longint'(b) - 2048;
        r_sum[which][2] += longint'(c) - 2048;
        r_sum[which][3] += longint'(d) - 2048;
    endtask

    task automatic rnd_frame(input int which);
        frame(which, $urandom_range(0, 4095), $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095));
    endtask

    task automatic clear_sums;
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 4; k++) r_sum[w][k] = 0;
    endtask

    // Called right after the edge that accepted the block's last word
    task automatic finish_block(input int which, input string tag);
        model(which);
        for (int i = 1; i <= 7; i++) begin
            tick;
            chk($sformatf("%s_valid_e%0d", tag, i), (which == 0) ? w_ov0 : w_ov1, (i == 7) ? 1 : 0);
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_out%0d", tag, k), dout(which, k), m_out[k]);
        if (m_sat) esat[which] = 1'b1;
        chk({tag, "_sat"}, (which == 0) ? w_sat0 : w_sat1, esat[which]);
        tick;
        chk({tag, "_pulse"}, (which == 0) ? w_ov0 : w_ov1, 0);
        for (int k = 0; k < 4; k++) r_sum[which][k] = 0;
    endtask

    task automatic chk_reset(input string tag);
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) chk($sformatf("%s_d%0d_out%0d", tag, w, k), dout(w, k), 0);
            chk($sformatf("%s_d%0d_valid", tag, w), (w == 0) ? w_ov0 : w_ov1, 0);
            chk($sformatf("%s_d%0d_overrun", tag, w), (w == 0) ? w_or0 : w_or1, 0);
            chk($sformatf("%s_d%0d_sat", tag, w), (w == 0) ? w_sat0 : w_sat1, 0);
            chk($sformatf("%s_d%0d_err", tag, w), (w == 0) ? w_err0 : w_err1, 0);
        end
    endtask

    task automatic chk_basic(input string tag);
        chk({tag, "_ialpham"}, dout(0, 0), 26214400);
        chk({tag, "_ibetam"},  dout(0, 1), 0);
        chk({tag, "_valpha"},  dout(0, 2), 262144000);
        chk({tag, "_vbeta"},   dout(0, 3), 151349000);
    endtask

    initial begin
        longint pend [4];
        longint last_t;
        int     n_ov, n_or, cnt;
        bit     pub;
        bit     exp_or;

        clear_sums();
        esat[0] = 1'b0;
        esat[1] = 1'b0;
        repeat (3) tick;
        chk_reset("reset");
        reset = 1'b0;
        tick;

        // Basic transform
        repeat (4) frame(0, 2148, 1998, 3048, 2048);
        finish_block(0, "basic");
        chk_basic("basic");

        // Averaging truncation toward -inf
        frame(0, 2049, 2048, 2048, 2048); frame(0, 2050, 2048, 2048, 2048);
        frame(0, 2049, 2048, 2048, 2048); frame(0, 2050, 2048, 2048, 2048);
        finish_block(0, "trunc_pos");
        chk("trunc_pos_ia", dout(0, 0), 262144);
        frame(0, 2047, 2048, 2048, 2048); frame(0, 2046, 2048, 2048, 2048);
        frame(0, 2047, 2048, 2048, 2048); frame(0, 2046, 2048, 2048, 2048);
        finish_block(0, "trunc_neg");
        chk("trunc_neg_ia", dout(0, 0), -524288);

        // Framing: 0,1,3 discards the partial frame
        put(0, 0, 1000); put(0, 1, 1000); put(0, 3, 1000);
        chk("frame_err1", w_err0, 1);
        repeat (4) frame(0, 2148, 1998, 3048, 2048);
        finish_block(0, "frame_clean");
        chk_basic("frame_clean");

        // Unexpected channel 0 restarts the frame with that word
        put(0, 0, 17); put(0, 1, 4000);
        repeat (4) rnd_frame(0);
        chk("frame_err2", w_err0, 2);
        finish_block(0, "frame_restart");

        // Error mid-block leaves completed frames intact
        repeat (2) rnd_frame(0);
        put(0, 0, 4095); put(0, 2, 0);
        repeat (2) rnd_frame(0);
        chk("frame_err3", w_err0, 3);
        finish_block(0, "frame_mid");

        for (int b = 0; b < 5; b++) begin
            repeat (4) rnd_frame(0);
            finish_block(0, $sformatf("rand%0d", b));
        end

        // Reset during compute
        repeat (4) rnd_frame(0);
        tick; tick;
        #3 reset = 1'b1;
        #1;
        chk_reset("abort");
        tick; tick;
        reset = 1'b0;
        clear_sums();
        esat[0] = 1'b0;
        esat[1] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (w_ov0) cnt++;
        end
        chk("abort_no_valid", cnt, 0);
        repeat (4) rnd_frame(0);
        finish_block(0, "after_abort");

        // Saturation on the single-frame instance
        frame(1, 2048, 2048, 4095, 2048);
        finish_block(1, "sat");
        chk("sat_valpha", dout(1, 2), c_MAX);
        chk("sat_flag", w_sat1, 1);
        frame(1, 2048, 2048, 2048, 2048);
        finish_block(1, "sat_sticky");
        chk("sat_sticky_flag", w_sat1, 1);

        // Continuous stream: blocks landing in a busy compute window are dropped
        last_t = -100;
        n_ov = 0;
        n_or = 0;
        for (int t = 0; t < 34; t++) begin
            if (t < 24) begin
                int dv;
                dv = $urandom_range(0, 4095);
                put(1, t % 4, dv);
                r_sum[1][t % 4] += longint'(dv) - 2048;
            end else begin
                tick;
            end
            pub = (t == last_t + 7);
            chk($sformatf("stream_valid_t%0d", t), w_ov1, pub ? 1 : 0);
            if (pub) begin
                for (int k = 0; k < 4; k++) chk($sformatf("stream_out%0d_t%0d", k, t), dout(1, k), pend[k]);
                chk($sformatf("stream_sat_t%0d", t), w_sat1, esat[1]);
            end
            exp_or = 1'b0;
            if (t < 24 && (t % 4) == 3) begin
                if (t >= last_t + 1 && t <= last_t + 6) begin
                    exp_or = 1'b1;
                end else begin
                    model(1);
                    for (int k = 0; k < 4; k++) pend[k] = m_out[k];
                    if (m_sat) esat[1] = 1'b1;
                    last_t = t;
                end
                for (int k = 0; k < 4; k++) r_sum[1][k] = 0;
            end
            chk($sformatf("stream_overrun_t%0d", t), w_or1, exp_or ? 1 : 0);
            if (w_ov1) n_ov++;
            if (w_or1) n_or++;
        end
        chk("stream_n_valid", n_ov, 3);
        chk("stream_n_overrun", n_or, 3);
        chk("stream_err", w_err1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
